// File: rtl/a2d_rr_intf.sv
`default_nettype none
// ============================================================================
// Module   : a2d_rr_intf
// Brief    : Round-robin SPI master for an off-board 8-channel 12-bit A2D.
//            Converts batt/curr/brake/torque and holds the latest results.
//            Optional macro A2D_AVG2_EN: two-point rounding average per channel.
// Revision : 1.0 - initial release
// ============================================================================
module a2d_rr_intf #(
  parameter int CONV_PERIOD_W = 14,
  parameter int SCLK_DIV_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic        cnv_cmplt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TX1  = 3'd1,
    GAP  = 3'd2,
    TX2  = 3'd3,
    UPD  = 3'd4
  } state_t;

  // Divider preload puts the first SCLK fall a few clocks after SS_n drops
  localparam logic [SCLK_DIV_W-1:0] c_DIV_LOAD   = {1'b1, {(SCLK_DIV_W-4){1'b0}}, 3'b111};
  localparam logic [SCLK_DIV_W-1:0] c_DIV_SAMPLE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] c_DIV_SHIFT  = {SCLK_DIV_W{1'b1}};

  state_t                   r_state;
  logic [CONV_PERIOD_W-1:0] r_period;
  logic [SCLK_DIV_W-1:0]    r_div;
  logic [15:0]              r_shft;
  logic [4:0]               r_bit_cnt;
  logic [1:0]               r_idx;
  logic                     r_ss_n;
  logic                     r_miso;
  logic                     r_gap;
  logic                     r_cnv_cmplt;
  logic [11:0]              r_batt;
  logic [11:0]              r_curr;
  logic [11:0]              r_brake;
  logic [11:0]              r_torque;

  logic [2:0]               w_chnl;
  logic [15:0]              w_cmd;
  logic [15:0]              w_rx;
  logic [11:0]              w_new;
  logic                     w_start;
  logic                     w_tx_done;

  always_comb begin
    case (r_idx)
      2'd0:    w_chnl = 3'd0;
      2'd1:    w_chnl = 3'd1;
      2'd2:    w_chnl = 3'd3;
      default: w_chnl = 3'd4;
    endcase
    w_cmd     = {2'b00, w_chnl, 11'h000};
    w_rx      = {r_shft[14:0], r_miso};
    w_start   = &r_period;
    w_tx_done = (r_div == c_DIV_SHIFT) && (r_bit_cnt == 5'd16);
  end

`ifdef A2D_AVG2_EN
  logic [3:0]  r_vld;
  logic [11:0] w_old;

  always_comb begin
    case (r_idx)
      2'd0:    w_old = r_batt;
      2'd1:    w_old = r_curr;
      2'd2:    w_old = r_brake;
      default: w_old = r_torque;
    endcase
    w_new = r_vld[r_idx] ? 12'(({1'b0, w_old} + {1'b0, w_rx[11:0]} + 13'd1) >> 1)
                         : w_rx[11:0];
  end
`else
  assign w_new = w_rx[11:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_period <= '0;
    else     r_period <= r_period + CONV_PERIOD_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ss_n      <= 1'b1;
      r_shft      <= '0;
      r_div       <= '0;
      r_bit_cnt   <= '0;
      r_miso      <= 1'b0;
      r_gap       <= 1'b0;
      r_idx       <= '0;
      r_cnv_cmplt <= 1'b0;
      r_batt      <= '0;
      r_curr      <= '0;
      r_brake     <= '0;
      r_torque    <= '0;
`ifdef A2D_AVG2_EN
      r_vld       <= '0;
`endif
    end else begin
      r_cnv_cmplt <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_ss_n    <= 1'b0;
            r_shft    <= w_cmd;
            r_div     <= c_DIV_LOAD;
            r_bit_cnt <= '0;
            r_state   <= TX1;
          end
        end
        TX1, TX2: begin
          r_div <= r_div + SCLK_DIV_W'(1);
          if (r_div == c_DIV_SAMPLE) begin
            r_miso    <= MISO;
            r_bit_cnt <= r_bit_cnt + 5'd1;
          end
          if ((r_div == c_DIV_SHIFT) && (r_bit_cnt != 5'd0))
            r_shft <= w_rx;
          if (w_tx_done) begin
            r_ss_n <= 1'b1;
            if (r_state == TX1) begin
              r_gap   <= 1'b0;
              r_state <= GAP;
            end else begin
              // Result lands on UPD entry so it is visible while cnv_cmplt is high
              case (r_idx)
                2'd0:    r_batt   <= w_new;
                2'd1:    r_curr   <= w_new;
                2'd2:    r_brake  <= w_new;
                default: r_torque <= w_new;
              endcase
`ifdef A2D_AVG2_EN
              r_vld[r_idx] <= 1'b1;
`endif
              r_cnv_cmplt <= 1'b1;
              r_state     <= UPD;
            end
          end
        end
        GAP: begin
          r_gap <= 1'b1;
          if (r_gap) begin
            r_ss_n    <= 1'b0;
            r_shft    <= w_cmd;
            r_div     <= c_DIV_LOAD;
            r_bit_cnt <= '0;
            r_state   <= TX2;
          end
        end
        UPD: begin
          r_idx   <= r_idx + 2'd1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign SS_n      = r_ss_n;
  assign SCLK      = r_ss_n ? 1'b1 : r_div[SCLK_DIV_W-1];
  assign MOSI      = r_shft[15];
  assign batt      = r_batt;
  assign curr      = r_curr;
  assign brake     = r_brake;
  assign torque    = r_torque;
  assign cnv_cmplt = r_cnv_cmplt;

endmodule
`default_nettype wire

// File: tb/tb_a2d_rr_intf.sv
`default_nettype none
// Testbench for a2d_rr_intf: A2D slave model, queued expected SPI commands and
// result snapshots, checked by a monitor whenever a transaction or update completes.
module tb_a2d_rr_intf;
  localparam int PW = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miso = 1'b0;
  logic        ss_n, sclk, mosi, cnv_cmplt;
  logic [11:0] batt, curr, brake, torque;

  int tests = 0;
  int fails = 0;

  a2d_rr_intf #(.CONV_PERIOD_W(PW), .SCLK_DIV_W(5)) dut (
    .clk(clk), .rst(rst), .MISO(miso), .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi),
    .batt(batt), .curr(curr), .brake(brake), .torque(torque), .cnv_cmplt(cnv_cmplt)
  );

  always #5 clk = ~clk;

  logic [15:0] exp_cmd[$];
  logic [47:0] exp_res[$];
  logic [11:0] mdl [4];
  logic [3:0]  mdl_vld;
  logic [1:0]  bidx;
  logic [11:0] a2d_val = 12'h000;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string what);
    tests++;
    fails++;
    $display("FAIL %s: %s", name, what);
  endtask

  // A2D slave: MSB-first response, next bit presented on each SCLK fall
  int          fall_idx = 0;
  logic [15:0] resp = 16'h0000;
  always @(negedge ss_n) begin
    fall_idx = 0;
    resp     = {4'hF, a2d_val};
  end
  always @(negedge sclk) begin
    if (!ss_n && fall_idx < 16) begin
      miso = resp[15-fall_idx];
      fall_idx++;
    end
  end

  // Monitor
  int          cyc = 0, last_rise = -1, rises = 0, falls = 0;
  int          per_bad = 0, mosi_bad = 0, idle_bad = 0, hi_run = 0, win_cnt = 0;
  logic        prev_ss = 1'b1, prev_sclk = 1'b1, prev_mosi = 1'b0, prev_cnv = 1'b0;
  logic        in_win = 1'b0, expect_gap = 1'b0;
  logic [15:0] word = 16'h0000;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_win = 0; win_cnt = 0; expect_gap = 0; hi_run = 0; idle_bad = 0;
      prev_ss = 1; prev_sclk = 1; prev_cnv = 0; prev_mosi = 0;
    end else begin
      if (ss_n && !sclk) idle_bad++;
      if (!ss_n && prev_ss) begin
        if (expect_gap) chk("ss_gap_clocks", hi_run, 2);
        expect_gap = 0;
        in_win = 1; rises = 0; falls = 0; per_bad = 0; mosi_bad = 0;
        last_rise = -1; word = 16'h0000;
      end
      hi_run = ss_n ? hi_run + 1 : 0;
      if (in_win && !ss_n) begin
        if (prev_sclk && !sclk) falls++;
        if (!prev_sclk && sclk) begin
          rises++;
          word = {word[14:0], mosi};
          if (mosi !== prev_mosi) mosi_bad++;
          if (last_rise >= 0 && cyc - last_rise != 32) per_bad++;
          last_rise = cyc;
        end
      end
      if (in_win && ss_n && !prev_ss) begin
        in_win = 0;
        win_cnt++;
        if (exp_cmd.size() == 0) flag("spi_unexpected", $sformatf("window %0d with no expected command", win_cnt));
        else chk("mosi_cmd", word, exp_cmd.pop_front());
        chk("sclk_falls", falls, 16);
        chk("sclk_rises", rises, 16);
        chk("spi_timing_errs", per_bad + mosi_bad + idle_bad, 0);
        idle_bad = 0;
        expect_gap = win_cnt[0];
      end
      if (prev_cnv) chk("cnv_width", cnv_cmplt, 0);
      if (cnv_cmplt && !prev_cnv) begin
        if (exp_res.size() == 0) flag("cnv_unexpected", "cnv_cmplt with no expected update");
        else chk("results", {batt, curr, brake, torque}, exp_res.pop_front());
      end
      prev_ss = ss_n; prev_sclk = sclk; prev_mosi = mosi; prev_cnv = cnv_cmplt;
    end
  end

  function automatic logic [15:0] cmd_of(input logic [1:0] i);
    case (i)
      2'd0:    cmd_of = 16'h0000;
      2'd1:    cmd_of = 16'h0800;
      2'd2:    cmd_of = 16'h1800;
      default: cmd_of = 16'h2000;
    endcase
  endfunction

  task automatic expect_conv(input logic [11:0] val);
    logic [12:0] sum;
    a2d_val = val;
    exp_cmd.push_back(cmd_of(bidx));
    exp_cmd.push_back(cmd_of(bidx));
`ifdef A2D_AVG2_EN
    sum = {1'b0, mdl[bidx]} + {1'b0, val} + 13'd1;
    mdl[bidx] = mdl_vld[bidx] ? sum[12:1] : val;
    mdl_vld[bidx] = 1'b1;
`else
    sum = 13'd0;
    mdl[bidx] = val;
`endif
    exp_res.push_back({mdl[0], mdl[1], mdl[2], mdl[3]});
    bidx = bidx + 2'd1;
  endtask

  task automatic wait_cmplt();
    int n = 0;
    while (cnv_cmplt !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("cnv_cmplt_seen", cnv_cmplt, 1);
    @(negedge clk);
  endtask

  initial begin
    int   n, k;
    logic p;
    bidx = 0; mdl_vld = 0; mdl = '{default: 12'h000};
    rst = 1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ss_n, sclk, mosi, cnv_cmplt}, 4'b1100);
    chk("reset_results", {batt, curr, brake, torque}, 48'h0);

    // Single conversion on ch0, then release reset and check start timing
    expect_conv(12'hA5C);
    rst = 0;
    repeat (2047) @(posedge clk);
    #1 chk("idle_before_start", ss_n, 1);
    @(posedge clk);
    #1 chk("start_at_period", ss_n, 0);
    wait_cmplt();

    // Round-robin through ch1, ch3, ch4 and back to ch0
    expect_conv(12'h101); wait_cmplt();
    expect_conv(12'h103); wait_cmplt();
    expect_conv(12'h104); wait_cmplt();
    expect_conv(12'h100); wait_cmplt();

    // Abort ch1 conversion at the 8th SCLK rise of the second transaction
    a2d_val = 12'h3C3;
    exp_cmd.push_back(cmd_of(bidx));
    n = 0; k = 0; p = ss_n;
    while (k < 2 && n < 4000) begin
      @(negedge clk); n++;
      if (p && !ss_n) k++;
      p = ss_n;
    end
    chk("tx2_start_seen", k, 2);
    n = 0; k = 0; p = sclk;
    while (k < 8 && n < 1000) begin
      @(negedge clk); n++;
      if (!p && sclk) k++;
      p = sclk;
    end
    chk("sclk_rise8_seen", k, 8);
    rst = 1;
    #1;
    chk("abort_outputs", {ss_n, sclk, mosi, cnv_cmplt}, 4'b1100);
    chk("abort_results", {batt, curr, brake, torque}, 48'h0);
    exp_cmd.delete(); exp_res.delete();
    bidx = 0; mdl_vld = 0; mdl = '{default: 12'h000};
    repeat (3) @(negedge clk);

    // After reset: ch0 first, then averaging (or raw) on the second ch0 update
    expect_conv(12'h800);
    rst = 0;
    wait_cmplt();
    expect_conv(12'h011); wait_cmplt();
    expect_conv(12'h033); wait_cmplt();
    expect_conv(12'h044); wait_cmplt();
    expect_conv(12'h001); wait_cmplt();

    repeat (10) @(negedge clk);
    chk("cmd_queue_empty", exp_cmd.size(), 0);
    chk("res_queue_empty", exp_res.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
